// File: rtl/stack_ptr_encoder_if.sv
// Command/status bundle between the stack controller and the
// top-of-stack pointer tracker.
interface stack_ptr_encoder_if;
    logic       PUSH;
    logic       POP;
    logic       LOAD;
    logic [7:0] D;
    logic       CLR_ERR;
    logic [7:0] SEL;
    logic [2:0] PTR;
    logic [3:0] COUNT;
    logic       EMPTY;
    logic       FULL;
    logic       ERR;

    modport master (
        output PUSH, POP, LOAD, D, CLR_ERR,
        input  SEL, PTR, COUNT, EMPTY, FULL, ERR
    );

    modport slave (
        input  PUSH, POP, LOAD, D, CLR_ERR,
        output SEL, PTR, COUNT, EMPTY, FULL, ERR
    );
endinterface

// File: rtl/stack_ptr_encoder.sv
// One-hot top-of-stack register for the 8-slot stack, encoded back
// to a binary pointer with occupancy, full/empty and sticky error.
module stack_ptr_encoder #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic CLK,
    input  logic RST_N,
    stack_ptr_encoder_if.slave bus
);
    logic [DEPTH-1:0] sel_q, sel_d;
    logic             err_q, err_d;
    logic             err_set;
    logic             d_multi;
    logic             empty;
    logic [PTR_W-1:0] ptr;

    assign empty   = (sel_q == '0);
    assign d_multi = |(bus.D & (bus.D - 8'd1));

    always_comb begin
        sel_d   = sel_q;
        err_set = 1'b0;
        if (bus.LOAD) begin
            if (d_multi) err_set = 1'b1;
            else         sel_d   = bus.D;
        end else if (bus.PUSH && !bus.POP) begin
            if (sel_q[DEPTH-1]) err_set = 1'b1;
            else if (empty)     sel_d   = DEPTH'(1);
            else                sel_d   = sel_q << 1;
        end else if (bus.POP && !bus.PUSH) begin
            if (empty) err_set = 1'b1;
            else       sel_d   = sel_q >> 1;
        end
        // A new error outranks a same-cycle clear
        err_d = err_set | (err_q & ~bus.CLR_ERR);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sel_q <= '0;
            err_q <= 1'b0;
        end else begin
            sel_q <= sel_d;
            err_q <= err_d;
        end
    end

    always_comb begin
        ptr = '0;
        unique case (1'b1)
            sel_q[0]: ptr = 3'd0;
            sel_q[1]: ptr = 3'd1;
            sel_q[2]: ptr = 3'd2;
            sel_q[3]: ptr = 3'd3;
            sel_q[4]: ptr = 3'd4;
            sel_q[5]: ptr = 3'd5;
            sel_q[6]: ptr = 3'd6;
            sel_q[7]: ptr = 3'd7;
            default:  ptr = 3'd0;
        endcase
    end

    assign bus.SEL   = sel_q;
    assign bus.PTR   = ptr;
    assign bus.COUNT = empty ? 4'd0 : {1'b0, ptr} + 4'd1;
    assign bus.EMPTY = empty;
    assign bus.FULL  = sel_q[DEPTH-1];
    assign bus.ERR   = err_q;
endmodule

// File: tb/tb_stack_ptr_encoder.sv
// Directed bench for stack_ptr_encoder with an index-based reference
// model feeding a queue of expected post-edge states.
module tb_stack_ptr_encoder;
    logic CLK;
    logic RST_N;

    stack_ptr_encoder_if bus ();

    stack_ptr_encoder #(.DEPTH(8), .PTR_W(3)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] sel;
        logic [2:0] ptr;
        logic [3:0] cnt;
        logic       empty;
        logic       full;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   passed = 0;
    int   total  = 0;
    int   failed = 0;
    int   top    = -1;
    logic merr   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model_state();
        exp_t e;
        logic [7:0] one;
        one     = 8'h01;
        e.sel   = (top < 0) ? 8'h00 : (one << top);
        e.ptr   = (top < 0) ? 3'd0 : 3'(top);
        e.cnt   = 4'(top + 1);
        e.empty = (top < 0);
        e.full  = (top == 7);
        e.err   = merr;
        return e;
    endfunction

    task automatic check_outputs(input string tag, input exp_t e);
        logic [7:0] one;
        one = 8'h01;
        chk({tag, ".sel"},   bus.SEL,   e.sel);
        chk({tag, ".ptr"},   bus.PTR,   e.ptr);
        chk({tag, ".cnt"},   bus.COUNT, e.cnt);
        chk({tag, ".empty"}, bus.EMPTY, e.empty);
        chk({tag, ".full"},  bus.FULL,  e.full);
        chk({tag, ".err"},   bus.ERR,   e.err);
        chk({tag, ".inv_1hot"}, ($countones(bus.SEL) <= 1), 1);
        chk({tag, ".inv_empty"}, bus.EMPTY, (bus.COUNT == 4'd0));
        chk({tag, ".inv_full"},  bus.FULL,  (bus.COUNT == 4'd8));
        if (bus.SEL != 8'h00)
            chk({tag, ".inv_ptr"}, bus.SEL, one << bus.PTR);
    endtask

    task automatic model_step(input logic push, input logic pop,
                              input logic load, input logic [7:0] d,
                              input logic clr);
        int ones;
        int idx;
        logic eset;
        eset = 1'b0;
        if (load) begin
            ones = 0;
            idx  = -1;
            for (int i = 0; i < 8; i++)
                if (d[i]) begin
                    ones++;
                    idx = i;
                end
            if (ones > 1) eset = 1'b1;
            else          top  = idx;
        end else if (push && !pop) begin
            if (top == 7) eset = 1'b1;
            else          top++;
        end else if (pop && !push) begin
            if (top < 0) eset = 1'b1;
            else         top--;
        end
        if (eset)     merr = 1'b1;
        else if (clr) merr = 1'b0;
    endtask

    task automatic step(input string tag, input logic push,
                        input logic pop, input logic load,
                        input logic [7:0] d, input logic clr);
        exp_t e;
        bus.PUSH    = push;
        bus.POP     = pop;
        bus.LOAD    = load;
        bus.D       = d;
        bus.CLR_ERR = clr;
        model_step(push, pop, load, d, clr);
        exp_q.push_back(model_state());
        @(posedge CLK);
        #1;
        bus.PUSH    = 1'b0;
        bus.POP     = 1'b0;
        bus.LOAD    = 1'b0;
        bus.D       = 8'h00;
        bus.CLR_ERR = 1'b0;
        if (exp_q.size() == 0) begin
            chk({tag, ".queue"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            check_outputs(tag, e);
        end
    endtask

    task automatic push(input string t); step(t, 1, 0, 0, 8'h00, 0); endtask
    task automatic pop(input string t);  step(t, 0, 1, 0, 8'h00, 0); endtask
    task automatic clr(input string t);  step(t, 0, 0, 0, 8'h00, 1); endtask
    task automatic load(input string t, input logic [7:0] d);
        step(t, 0, 0, 1, d, 0);
    endtask

    initial begin
        RST_N       = 1'b0;
        bus.PUSH    = 1'b0;
        bus.POP     = 1'b0;
        bus.LOAD    = 1'b0;
        bus.D       = 8'h00;
        bus.CLR_ERR = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_outputs("reset", model_state());
        RST_N = 1'b1;

        for (int i = 0; i < 8; i++) push($sformatf("push%0d", i));

        push("push_full");
        clr("clr_err");
        for (int i = 0; i < 8; i++) pop($sformatf("pop%0d", i));
        pop("pop_empty");

        clr("clr2");
        load("load20", 8'h20);
        load("load24", 8'h24);
        load("load00", 8'h00);

        clr("clr3");
        step("pp_empty", 1, 1, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) push($sformatf("up%0d", i));
        step("pp_ptr3", 1, 1, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) push($sformatf("upf%0d", i));
        step("pp_full", 1, 1, 0, 8'h00, 0);
        step("load_push", 1, 0, 1, 8'h04, 0);

        for (int i = 0; i < 3; i++) pop($sformatf("dn%0d", i));
        step("pop_clr", 0, 1, 0, 8'h00, 1);

        clr("clr4");
        load("load10", 8'h10);
        #3;
        RST_N = 1'b0;
        #1;
        top  = -1;
        merr = 1'b0;
        exp_q.delete();
        check_outputs("async_rst", model_state());
        @(posedge CLK);
        #1;
        check_outputs("rst_hold", model_state());
        RST_N = 1'b1;
        push("post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
